// File: rtl/cpu_mem_arb_pkg.sv
// Shared types, requester indices and small helpers for the CPU data-memory arbiter.
package cpu_mem_arb_pkg;

  // Arbiter modes: free round-robin, or accelerator holding the memory for a burst.
  typedef enum logic {
    ARB  = 1'b0,
    LOCK = 1'b1
  } arb_state_t;

  // Requester indices, also the bit positions in every request/grant vector.
  localparam int REQ_CPU   = 0;
  localparam int REQ_EX    = 1;
  localparam int REQ_ACCEL = 2;
  localparam int NUM_REQ   = 3;

  // Priority pointer after serving index idx: the next index, wrapping after the last.
  function automatic logic [1:0] next_ptr(input logic [1:0] idx);
    return (idx == 2'(NUM_REQ - 1)) ? 2'd0 : idx + 2'd1;
  endfunction

  // Index of the set bit in a one-hot grant vector (0 when no bit is set).
  function automatic logic [1:0] onehot_idx(input logic [NUM_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (oh[k]) idx = 2'(k);
    end
    return idx;
  endfunction

endpackage

// File: rtl/cpu_rr_pick.sv
// Combinational 3-way round-robin picker: the first requester found when scanning
// from i_ptr upwards (wrapping) gets the single one-hot grant.
module cpu_rr_pick
  import cpu_mem_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [1:0]         i_ptr,
  output logic [NUM_REQ-1:0] o_gnt
);

  logic       w_found;
  logic [2:0] w_idx;

  // Scan ptr, ptr+1, ptr+2 (mod 3) and grant the first active request.
  always_comb begin
    o_gnt   = '0;
    w_found = 1'b0;
    w_idx   = 3'd0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = 3'(i_ptr) + 3'(k);
      if (w_idx >= 3'(NUM_REQ)) w_idx = w_idx - 3'(NUM_REQ);
      if (!w_found && i_req[w_idx[1:0]]) begin
        o_gnt[w_idx[1:0]] = 1'b1;
        w_found           = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_mem_arb.sv
// Shares the single-ported CPU data memory between the CPU MEM stage, the host
// interface and the accelerator. One access per cycle, round-robin priority, an
// accelerator burst lock, a one-cycle read return path and the CPU stall.
module cpu_mem_arb
  import cpu_mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_LOCK = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cpu_req,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  input  logic              ex_req,
  input  logic              ex_wr,
  input  logic [ADDR_W-1:0] ex_addr,
  input  logic [DATA_W-1:0] ex_wdata,
  input  logic              accel_req,
  input  logic              accel_wr,
  input  logic [ADDR_W-1:0] accel_addr,
  input  logic [DATA_W-1:0] accel_wdata,
  input  logic              accel_lock,
  output logic              cpu_gnt,
  output logic              ex_gnt,
  output logic              accel_gnt,
  output logic              cpu_rvalid,
  output logic              ex_rvalid,
  output logic              accel_rvalid,
  output logic [DATA_W-1:0] rd_data,
  output logic              cpu_stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Wide enough to hold MAX_LOCK itself so the count saturates instead of wrapping.
  localparam int LCW = $clog2(MAX_LOCK + 1);

  arb_state_t         r_state;
  arb_state_t         w_state_next;
  logic [1:0]         r_ptr;
  logic [1:0]         w_ptr_next;
  logic [1:0]         w_pick_ptr;
  logic [LCW-1:0]     r_lock_cnt;
  logic [LCW-1:0]     w_lock_cnt_next;
  logic               w_lock_cont;
  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_pick_gnt;
  logic [NUM_REQ-1:0] w_gnt;
  logic [1:0]         w_gnt_idx;
  logic [NUM_REQ-1:0] w_wr_vec;
  logic [ADDR_W-1:0]  w_addr_arr  [NUM_REQ];
  logic [DATA_W-1:0]  w_wdata_arr [NUM_REQ];
  logic               w_mem_wr;
  logic [ADDR_W-1:0]  w_mem_addr;
  logic [DATA_W-1:0]  w_mem_wdata;
  logic               r_rd_vld;
  logic [1:0]         r_rd_idx;
  logic [NUM_REQ-1:0] w_rvalid;

  // Gather the per-requester buses into indexable vectors.
  assign w_req[REQ_CPU]          = cpu_req;
  assign w_req[REQ_EX]           = ex_req;
  assign w_req[REQ_ACCEL]        = accel_req;
  assign w_wr_vec[REQ_CPU]       = cpu_wr;
  assign w_wr_vec[REQ_EX]        = ex_wr;
  assign w_wr_vec[REQ_ACCEL]     = accel_wr;
  assign w_addr_arr[REQ_CPU]     = cpu_addr;
  assign w_addr_arr[REQ_EX]      = ex_addr;
  assign w_addr_arr[REQ_ACCEL]   = accel_addr;
  assign w_wdata_arr[REQ_CPU]    = cpu_wdata;
  assign w_wdata_arr[REQ_EX]     = ex_wdata;
  assign w_wdata_arr[REQ_ACCEL]  = accel_wdata;

  // The burst continues only while the accelerator still asks for it and has budget left.
  assign w_lock_cont = (r_state == LOCK) && accel_req && accel_lock &&
                       (r_lock_cnt < LCW'(MAX_LOCK));

  // Leaving a lock re-arbitrates from index 0 so the waiting CPU/host go first.
  assign w_pick_ptr = (r_state == LOCK) ? 2'd0 : r_ptr;

  cpu_rr_pick u_pick (
    .i_req (w_req),
    .i_ptr (w_pick_ptr),
    .o_gnt (w_pick_gnt)
  );

  // Next-state, pointer and lock-count update; grants are forced low while in reset.
  always_comb begin
    w_state_next    = r_state;
    w_ptr_next      = r_ptr;
    w_lock_cnt_next = r_lock_cnt;
    w_gnt           = '0;
    if (w_lock_cont) begin
      w_gnt[REQ_ACCEL] = 1'b1;
      w_lock_cnt_next  = r_lock_cnt + LCW'(1);
      w_ptr_next       = next_ptr(2'(REQ_ACCEL));
    end else begin
      // Normal arbitration, also used in the cycle a lock ends.
      w_gnt           = w_pick_gnt;
      w_state_next    = ARB;
      w_lock_cnt_next = '0;
      if (|w_pick_gnt) begin
        w_ptr_next = next_ptr(onehot_idx(w_pick_gnt));
      end
      if (w_pick_gnt[REQ_ACCEL] && accel_lock) begin
        w_state_next    = LOCK;
        w_lock_cnt_next = LCW'(1);
      end
    end
    if (!rst_n) begin
      w_gnt = '0;
    end
  end

  assign w_gnt_idx = onehot_idx(w_gnt);

  // Route the granted requester's command to the memory; idle cycles drive zeros.
  always_comb begin
    w_mem_wr    = 1'b0;
    w_mem_addr  = '0;
    w_mem_wdata = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (w_gnt[k]) begin
        w_mem_wr    = w_wr_vec[k];
        w_mem_addr  = w_addr_arr[k];
        w_mem_wdata = w_wdata_arr[k];
      end
    end
  end

  // State, priority pointer, lock count and read-owner registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ARB;
      r_ptr      <= 2'd0;
      r_lock_cnt <= '0;
      r_rd_vld   <= 1'b0;
      r_rd_idx   <= 2'd0;
    end else begin
      r_state    <= w_state_next;
      r_ptr      <= w_ptr_next;
      r_lock_cnt <= w_lock_cnt_next;
      r_rd_vld   <= (|w_gnt) & ~w_mem_wr;
      r_rd_idx   <= w_gnt_idx;
    end
  end

  // One rvalid per requester; masked by reset so an in-flight read is dropped.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_rvalid
      assign w_rvalid[gi] = rst_n & r_rd_vld & (r_rd_idx == 2'(gi));
    end
  endgenerate

  assign cpu_gnt      = w_gnt[REQ_CPU];
  assign ex_gnt       = w_gnt[REQ_EX];
  assign accel_gnt    = w_gnt[REQ_ACCEL];
  assign cpu_rvalid   = w_rvalid[REQ_CPU];
  assign ex_rvalid    = w_rvalid[REQ_EX];
  assign accel_rvalid = w_rvalid[REQ_ACCEL];
  assign rd_data      = mem_rdata;
  assign cpu_stall    = cpu_req & ~w_gnt[REQ_CPU];
  assign mem_en       = |w_gnt;
  assign mem_wr       = w_mem_wr;
  assign mem_addr     = w_mem_addr;
  assign mem_wdata    = w_mem_wdata;

endmodule

// File: doc/cpu_mem_arb.md
# cpu_mem_arb

Arbiter that shares the single-ported CPU data memory between three requesters: the CPU pipeline MEM stage, the external host interface and the accelerator. It grants at most one access per cycle using round-robin priority. It supports an accelerator lock mode so that a 16-word (512-bit) block can be moved back-to-back. It sits between the requesters and the memory array and generates the CPU pipeline stall for lost arbitration.

## Interface
Parameters:
- ADDR_W, 16, word address width
- DATA_W, 32, data width
- MAX_LOCK, 16, maximum consecutive accelerator grants in one lock (>=2)

Ports (reset is synchronous and active-low; `rst_n` is sampled only on the rising edge of `clk`):
- clk  input  1  system clock; all state updates on its rising edge
- rst_n  input  1  reset, synchronous, active-low
- {cpu,ex,accel}_req  input  1 each  access request; held high until granted
- {cpu,ex,accel}_wr  input  1 each  1 = write, 0 = read; valid with req
- {cpu,ex,accel}_addr  input  ADDR_W each  word address
- {cpu,ex,accel}_wdata  input  DATA_W each  write data
- accel_lock  input  1  accelerator requests consecutive grants
- {cpu,ex,accel}_gnt  output  1 each  access accepted this cycle (combinational)
- {cpu,ex,accel}_rvalid  output  1 each  read data valid for that requester (registered)
- rd_data  output  DATA_W  read data, shared by all requesters, qualified by rvalid
- cpu_stall  output  1  cpu_req & ~cpu_gnt
- mem_en, mem_wr  output  1 each  memory command enable and write select
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory read data, valid 1 cycle after a read command

## Operation
- Requester indices: 0 = cpu, 1 = ex, 2 = accel.
- The state register `ptr` (2 bits) holds the highest-priority index. Reset value is 0.
- State machine:
  - ARB (reset state): grant the first requesting index scanning ptr, ptr+1, ptr+2 (mod 3). At most one gnt is high.
  - Any grant to index i sets ptr <= (i+1) mod 3.
  - If the accel grant occurs with accel_lock=1, go to LOCK and set lock_cnt <= 1.
- LOCK state:
  - Only accel can be granted. Grant when accel_req & accel_lock & (lock_cnt < MAX_LOCK); on each grant, lock_cnt <= lock_cnt + 1.
  - Exit to ARB in the same cycle, with no accel grant in that cycle, when accel_req=0, accel_lock=0 or lock_cnt == MAX_LOCK. In that cycle normal ARB arbitration applies with ptr = 0. The accel does not re-win immediately unless it is the only requester.
  - CPU and ex requests wait during LOCK; cpu_stall asserts while the CPU waits.
- Memory command:
  - mem_en = |gnt.
  - mem_wr, mem_addr and mem_wdata are muxed from the granted requester.
  - When no grant, mem_wr and mem_addr are 0.
- Read return:
  - owner/rd register captures {granted index, read} each cycle.
  - The next cycle the matching rvalid pulses for one cycle and rd_data = mem_rdata.
  - Writes never produce rvalid.
- Width: lock_cnt is $clog2(MAX_LOCK+1) bits and saturates; it never wraps.

## Timing
- Grant latency: 0 cycles (gnt in the same cycle as req when the requester wins).
- Read latency: rvalid 1 cycle after gnt.
- Throughput: 1 access per cycle, back-to-back across requesters.
- Reset values:
  - State: ARB, ptr=0, lock_cnt=0.
  - All gnt, rvalid, mem_en and mem_wr are 0; rd_data follows mem_rdata.
  - cpu_stall = cpu_req during reset, because gnts are forced 0.
- Reset mid-lock or with a read outstanding: state returns to ARB, the pending rvalid is dropped (not delivered after reset), and the lock is abandoned.
- A requester that drops req before gnt is simply not served; no state changes.
- A simultaneous new accel_lock with accel_req in LOCK at lock_cnt == MAX_LOCK exits; the accel re-competes in ARB the same cycle.

## Structure
- Package `cpu_mem_arb_pkg`:
  - typedef enum {ARB, LOCK} arb_state_t
  - localparams REQ_CPU=0, REQ_EX=1, REQ_ACCEL=2, NUM_REQ=3.
- Natural sub-module: `cpu_rr_pick`, a combinational 3-way round-robin picker (req vector and ptr in, one-hot grant out).
- The top holds the FSM, ptr, lock_cnt, owner register and the muxes.

## Test plan
- **Reset defaults:** after reset, cpu_req=1 read addr 0x0010 → cpu_gnt same cycle, mem_addr=0x0010; next cycle cpu_rvalid=1 with rd_data = mem_rdata.
- **Round-robin:** all three requesting continuously → grants cpu, ex, accel, cpu, ex… one per cycle; each gnt is one-hot.
- **Lock burst:** accel_lock=1 with 20 queued accel writes at 0x0100..0x0113 and cpu_req=1 → 16 consecutive accel grants (0x0100..0x010F), cpu_stall=1 throughout, then cpu granted on the next cycle.
- **Early lock release:** accel_lock drops after 5 grants while ex_req=1 → ex granted in the same cycle as the lock exit.
- **Writes produce no rvalid:** ex write 0xDEADBEEF to 0x0020 then ex read 0x0020 → no rvalid after the write; ex_rvalid follows the read with rd_data=0xDEADBEEF.
- **Reset mid-operation:** rst_n low the cycle after an accel read gnt in LOCK → no accel_rvalid, state ARB, ptr=0, and the next cpu_req is granted first.
